// File: rtl/pdp_mbist_ctrl.sv
// Built-in self-test master for a pseudo-dual-port RAM: runs an address sweep, March C- or
// LFSR random-data pattern, checks the read data and reports the pass/fail status and error count.
module pdp_mbist_ctrl #(
   parameter int unsigned DEPTH      = 512,
   parameter int unsigned ADDR_WIDTH = $clog2(DEPTH),
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned BYTE_WIDTH = 1,
   parameter int unsigned RD_LATENCY = 1,
   parameter logic [31:0] LFSR_SEED  = 32'hACE1_2468
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  start_i,
   input  logic [1:0]            mode_i,
   output logic                  busy_o,
   output logic                  done_o,
   output logic                  pass_o,
   output logic [15:0]           err_cnt_o,
   output logic [ADDR_WIDTH-1:0] err_addr_o,
   output logic                  wr_en_o,
   output logic [ADDR_WIDTH-1:0] wr_addr_o,
   output logic [DATA_WIDTH-1:0] wr_data_o,
   output logic [BYTE_WIDTH-1:0] ben_o,
   output logic                  rd_en_o,
   output logic [ADDR_WIDTH-1:0] rd_addr_o,
   input  logic [DATA_WIDTH-1:0] rd_data_i
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_e;
   typedef enum logic [1:0] {M_SWEEP = 2'd0, M_MARCH = 2'd1, M_LFSR = 2'd2} mode_e;

   localparam logic [31:0]           LFSR_TAPS = 32'h8020_0003;
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
   localparam int unsigned           CW        = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;

   state_e                state_q, state_d;
   mode_e                 mode_q, mode_d;
   logic [2:0]            elem_q, elem_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic                  phase_q, phase_d;
   logic [31:0]           lfsr_q, lfsr_d;
   logic [CW-1:0]         drain_q, drain_d;
   logic [15:0]           err_cnt_q, err_cnt_d;
   logic [ADDR_WIDTH-1:0] err_addr_q, err_addr_d;

   logic [RD_LATENCY-1:0]                 pipe_vld_q, pipe_vld_d;
   logic [RD_LATENCY-1:0][DATA_WIDTH-1:0] pipe_exp_q, pipe_exp_d;
   logic [RD_LATENCY-1:0][ADDR_WIDTH-1:0] pipe_addr_q, pipe_addr_d;

   logic                  op_wr, op_rd, pair, down, start_go, elem_end, next_down, miscmp;
   logic [DATA_WIDTH-1:0] op_data;
   logic [2:0]            last_elem, elem_nxt;

   // Operation decode for the current element/address; ports are idle outside RUN.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path can infer a latch.
      op_wr   = 1'b0;
      op_rd   = 1'b0;
      op_data = '0;
      pair    = 1'b0;
      down    = 1'b0;
      if (state_q == S_RUN) begin
         case (mode_q)
            M_MARCH: begin
               pair = (elem_q != 3'd0) && (elem_q != 3'd5);
               down = (elem_q == 3'd3) || (elem_q == 3'd4);
               if (elem_q == 3'd0) begin
                  op_wr = 1'b1;
               end else if (elem_q == 3'd5) begin
                  op_rd = 1'b1;
               end else if (!phase_q) begin
                  // odd elements read 0 and write 1, even elements the reverse
                  op_rd   = 1'b1;
                  op_data = {DATA_WIDTH{~elem_q[0]}};
               end else begin
                  op_wr   = 1'b1;
                  op_data = {DATA_WIDTH{elem_q[0]}};
               end
            end
            M_LFSR: begin
               op_wr   = (elem_q == 3'd0);
               op_rd   = (elem_q != 3'd0);
               op_data = lfsr_q[DATA_WIDTH-1:0];
            end
            default: begin
               op_wr   = (elem_q == 3'd0);
               op_rd   = (elem_q != 3'd0);
               op_data = DATA_WIDTH'(addr_q);
            end
         endcase
      end
   end

   // Sequencer: element/address/phase stepping and top-level state.
   always_comb begin
      state_d   = state_q;
      mode_d    = mode_q;
      elem_d    = elem_q;
      addr_d    = addr_q;
      phase_d   = phase_q;
      lfsr_d    = lfsr_q;
      drain_d   = drain_q;
      start_go  = 1'b0;
      last_elem = (mode_q == M_MARCH) ? 3'd5 : 3'd1;
      elem_nxt  = elem_q + 3'd1;
      next_down = (mode_q == M_MARCH) && ((elem_nxt == 3'd3) || (elem_nxt == 3'd4));
      elem_end  = down ? (addr_q == '0) : (addr_q == LAST_ADDR);
      case (state_q)
         S_IDLE, S_DONE: begin
            if (start_i) begin
               start_go = 1'b1;
               state_d  = S_RUN;
               mode_d   = (mode_i == 2'd3) ? M_SWEEP : mode_e'(mode_i);
               elem_d   = 3'd0;
               addr_d   = '0;
               phase_d  = 1'b0;
               lfsr_d   = LFSR_SEED;
            end
         end
         S_RUN: begin
            if (mode_q == M_LFSR) begin
               lfsr_d = (lfsr_q >> 1) ^ (lfsr_q[0] ? LFSR_TAPS : 32'd0);
            end
            if (pair && !phase_q) begin
               phase_d = 1'b1;
            end else begin
               phase_d = 1'b0;
               if (!elem_end) begin
                  addr_d = down ? addr_q - 1'b1 : addr_q + 1'b1;
               end else if (elem_q == last_elem) begin
                  state_d = S_DRAIN;
                  drain_d = '0;
               end else begin
                  elem_d = elem_nxt;
                  addr_d = next_down ? LAST_ADDR : '0;
                  lfsr_d = LFSR_SEED;
               end
            end
         end
         S_DRAIN: begin
            if (drain_q == CW'(RD_LATENCY - 1)) begin
               state_d = S_DONE;
            end else begin
               drain_d = drain_q + 1'b1;
            end
         end
         default: ;
      endcase
   end

   // Expected-data pipeline and error accounting.
   always_comb begin
      pipe_vld_d     = '0;
      pipe_exp_d     = '0;
      pipe_addr_d    = '0;
      pipe_vld_d[0]  = op_rd;
      pipe_exp_d[0]  = op_data;
      pipe_addr_d[0] = addr_q;
      for (int i = 1; i < RD_LATENCY; i++) begin
         pipe_vld_d[i]  = pipe_vld_q[i-1];
         pipe_exp_d[i]  = pipe_exp_q[i-1];
         pipe_addr_d[i] = pipe_addr_q[i-1];
      end
      miscmp     = pipe_vld_q[RD_LATENCY-1] && (rd_data_i != pipe_exp_q[RD_LATENCY-1]);
      err_cnt_d  = err_cnt_q;
      err_addr_d = err_addr_q;
      if (start_go) begin
         err_cnt_d  = '0;
         err_addr_d = '0;
      end else if (miscmp) begin
         if (err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
         if (err_cnt_q == 16'd0)    err_addr_d = pipe_addr_q[RD_LATENCY-1];
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= S_IDLE;
         mode_q     <= M_SWEEP;
         elem_q     <= 3'd0;
         addr_q     <= '0;
         phase_q    <= 1'b0;
         lfsr_q     <= LFSR_SEED;
         drain_q    <= '0;
         err_cnt_q  <= '0;
         err_addr_q <= '0;
         pipe_vld_q <= '0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so all flops update together.
         state_q    <= state_d;
         mode_q     <= mode_d;
         elem_q     <= elem_d;
         addr_q     <= addr_d;
         phase_q    <= phase_d;
         lfsr_q     <= lfsr_d;
         drain_q    <= drain_d;
         err_cnt_q  <= err_cnt_d;
         err_addr_q <= err_addr_d;
         pipe_vld_q <= pipe_vld_d;
      end
   end

   // NOTE: the data side of the pipeline needs no reset; it is only looked at when its valid bit is set.
   always_ff @(posedge clk_i) begin
      pipe_exp_q  <= pipe_exp_d;
      pipe_addr_q <= pipe_addr_d;
   end

   assign busy_o     = (state_q == S_RUN) || (state_q == S_DRAIN);
   assign done_o     = (state_q == S_DONE);
   assign pass_o     = done_o && (err_cnt_q == 16'd0);
   assign err_cnt_o  = err_cnt_q;
   assign err_addr_o = err_addr_q;
   assign wr_en_o    = op_wr;
   assign wr_addr_o  = op_wr ? addr_q : '0;
   assign wr_data_o  = op_wr ? op_data : '0;
   assign ben_o      = {BYTE_WIDTH{op_wr}};
   assign rd_en_o    = op_rd;
   assign rd_addr_o  = op_rd ? addr_q : '0;

endmodule

// File: tb/tb_pdp_mbist_ctrl.sv
// Self-checking bench: two controllers (read latency 1 and 2) share stimulus; each drives its own
// RAM model with an optional stuck-at bit. A pattern-level model predicts every op and the result.
module tb_pdp_mbist_ctrl;

   localparam int DEPTH = 16;

   logic clk = 1'b0;
   logic rst, start;
   logic [1:0] mode;

   logic        busy [2], done [2], pass [2], wr_en [2], rd_en [2];
   logic [15:0] err_cnt [2];
   logic [3:0]  err_addr [2], wr_addr [2], rd_addr [2];
   logic [7:0]  wr_data [2], rd_data [2];
   logic [0:0]  ben [2];

   bit         f_en;
   logic [3:0] f_addr;
   int         f_bit;
   bit         f_val;

   int n_checks = 0;
   int n_errs   = 0;

   always #5 clk = ~clk;

   function automatic logic [7:0] apply_fault(input logic [7:0] m, input logic [3:0] a);
      logic [7:0] bm;
      bm = 8'(1 << f_bit);
      if (f_en && a == f_addr) return f_val ? (m | bm) : (m & ~bm);
      return m;
   endfunction

   for (genvar g = 0; g < 2; g++) begin : g_dut
      logic [7:0] mem [DEPTH];
      logic [7:0] q1;

      pdp_mbist_ctrl #(.DEPTH(DEPTH), .DATA_WIDTH(8), .BYTE_WIDTH(1), .RD_LATENCY(g + 1)) u_dut (
         .clk_i(clk), .rst_i(rst), .start_i(start), .mode_i(mode),
         .busy_o(busy[g]), .done_o(done[g]), .pass_o(pass[g]),
         .err_cnt_o(err_cnt[g]), .err_addr_o(err_addr[g]),
         .wr_en_o(wr_en[g]), .wr_addr_o(wr_addr[g]), .wr_data_o(wr_data[g]), .ben_o(ben[g]),
         .rd_en_o(rd_en[g]), .rd_addr_o(rd_addr[g]), .rd_data_i(rd_data[g])
      );

      always @(posedge clk) begin
         if (wr_en[g]) mem[wr_addr[g]] <= wr_data[g];
         if (rd_en[g]) q1 <= apply_fault(mem[rd_addr[g]], rd_addr[g]);
      end

      if (g == 0) begin : g_l1
         assign rd_data[g] = q1;
      end else begin : g_l2
         logic [7:0] q2;
         always @(posedge clk) q2 <= q1;
         assign rd_data[g] = q2;
      end
   end

   // ---------------- pattern-level reference model ----------------
   typedef struct {
      bit         wr;
      logic [3:0] a;
      logic [7:0] d;
   } op_t;
   op_t exp_ops[$];

   function automatic logic [31:0] lfsr_next(input logic [31:0] x);
      return (x >> 1) ^ (x[0] ? 32'h8020_0003 : 32'd0);
   endfunction

   function automatic void push(input bit wr, input int a, input int d);
      op_t o;
      o.wr = wr;
      o.a  = 4'(a);
      o.d  = 8'(d);
      exp_ops.push_back(o);
   endfunction

   task automatic build_model(input int md, output int n_mis, output int first_a);
      int         rd_v [6] = '{-1, 0, 255, 0, 255, 0};
      int         wr_v [6] = '{0, 255, 0, 255, 0, -1};
      bit         dn   [6] = '{0, 0, 0, 1, 1, 0};
      logic [31:0] l;
      logic [7:0]  m [DEPTH];
      int a;
      exp_ops.delete();
      if (md == 1) begin
         for (int e = 0; e < 6; e++)
            for (int i = 0; i < DEPTH; i++) begin
               a = dn[e] ? DEPTH - 1 - i : i;
               if (rd_v[e] >= 0) push(1'b0, a, rd_v[e]);
               if (wr_v[e] >= 0) push(1'b1, a, wr_v[e]);
            end
      end else begin
         for (int e = 0; e < 2; e++) begin
            l = 32'hACE1_2468;
            for (int i = 0; i < DEPTH; i++) begin
               push(e == 0, i, (md == 2) ? int'(l[7:0]) : i);
               l = lfsr_next(l);
            end
         end
      end
      n_mis   = 0;
      first_a = 0;
      foreach (exp_ops[k]) begin
         if (exp_ops[k].wr) m[exp_ops[k].a] = exp_ops[k].d;
         else if (apply_fault(m[exp_ops[k].a], exp_ops[k].a) != exp_ops[k].d) begin
            if (n_mis == 0) first_a = exp_ops[k].a;
            n_mis++;
         end
      end
   endtask

   // ---------------- checking helpers ----------------
   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errs++;
         $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [63:0] port_vec(input int g);
      return 64'({busy[g], done[g], wr_en[g], rd_en[g], wr_addr[g], rd_addr[g], wr_data[g], ben[g]});
   endfunction

   function automatic logic [63:0] res_vec(input int g);
      return 64'({pass[g], err_cnt[g], err_addr[g]});
   endfunction

   function automatic logic [63:0] mk_vec(input bit b, input bit d, input bit w, input bit r,
                                          input logic [3:0] wa, input logic [3:0] ra, input logic [7:0] wd);
      return 64'({b, d, w, r, wa, ra, wd, w});
   endfunction

   task automatic do_run(input int md, input bit hold, input bit e_pass, input int e_cnt,
                         input int e_addr, input string tag);
      op_t o;
      int  n;
      @(negedge clk);
      start = 1'b1;
      mode  = 2'(md);
      @(negedge clk);
      if (!hold) start = 1'b0;
      n = exp_ops.size();
      for (int k = 0; k < n; k++) begin
         if (k == n - 1) start = 1'b0;
         o = exp_ops[k];
         for (int g = 0; g < 2; g++) begin
            if (k == 0) check($sformatf("%s_clear_l%0d", tag, g + 1), res_vec(g), 64'd0);
            check($sformatf("%s_op%0d_l%0d", tag, k, g + 1), port_vec(g),
                  mk_vec(1'b1, 1'b0, o.wr, !o.wr, o.wr ? o.a : 4'd0, o.wr ? 4'd0 : o.a, o.wr ? o.d : 8'd0));
         end
         @(negedge clk);
      end
      for (int c = 1; c <= 4; c++) begin
         for (int g = 0; g < 2; g++)
            check($sformatf("%s_tail%0d_l%0d", tag, c, g + 1), port_vec(g),
                  mk_vec(c < g + 2, c >= g + 2, 1'b0, 1'b0, 4'd0, 4'd0, 8'd0));
         if (c < 4) @(negedge clk);
      end
      for (int g = 0; g < 2; g++)
         check($sformatf("%s_result_l%0d", tag, g + 1), res_vec(g),
               64'({e_pass, 16'(e_cnt), 4'(e_addr)}));
      repeat (3) @(negedge clk);
      for (int g = 0; g < 2; g++)
         check($sformatf("%s_done_held_l%0d", tag, g + 1), 64'({done[g], pass[g]}), 64'({1'b1, e_pass}));
   endtask

   // ---------------- directed table ----------------
   typedef struct {
      int md;
      bit fe;
      int fa;
      int fb;
      bit fv;
      bit hold;
      bit e_pass;
      int e_cnt;
      int e_addr;
   } vec_t;

   initial begin
      vec_t tbl [10];
      int   n_mis, first_a, md;
      bit   seen_done;

      tbl[0] = '{0, 0, 0,  0, 0, 0, 1, 0, 0};   // clean sweep
      tbl[1] = '{1, 1, 5,  3, 0, 1, 0, 2, 5};   // March C-, bit3 of addr 5 stuck 0, start held
      tbl[2] = '{2, 0, 0,  0, 0, 0, 1, 0, 0};   // clean LFSR
      tbl[3] = '{3, 0, 0,  0, 0, 0, 1, 0, 0};   // mode 3 behaves as sweep
      tbl[4] = '{0, 1, 5,  3, 0, 0, 1, 0, 0};   // stuck bit matches sweep data: undetected
      tbl[5] = '{0, 1, 9,  3, 0, 0, 0, 1, 9};   // sweep data 0x09 reads 0x01
      tbl[6] = '{1, 1, 0,  0, 1, 0, 0, 3, 0};   // stuck-at-1 fails the three r0 elements at addr 0
      tbl[7] = '{2, 1, 2,  7, 1, 0, 0, 1, 2};   // LFSR data at addr 2 is 0x1A
      tbl[8] = '{0, 0, 0,  0, 0, 0, 1, 0, 0};   // restart from DONE clears the error count
      tbl[9] = '{1, 1, 15, 6, 0, 0, 0, 2, 15};  // leaves an error count for the reset check

      rst   = 1'b1;
      start = 1'b0;
      mode  = 2'd0;
      f_en  = 1'b0;
      f_addr = '0;
      f_bit = 0;
      f_val = 1'b0;
      repeat (2) @(negedge clk);
      for (int g = 0; g < 2; g++) begin
         check($sformatf("por_ports_l%0d", g + 1), port_vec(g), 64'd0);
         check($sformatf("por_result_l%0d", g + 1), res_vec(g), 64'd0);
      end
      rst = 1'b0;

      for (int i = 0; i < 10; i++) begin
         f_en   = tbl[i].fe;
         f_addr = 4'(tbl[i].fa);
         f_bit  = tbl[i].fb;
         f_val  = tbl[i].fv;
         build_model(tbl[i].md, n_mis, first_a);
         do_run(tbl[i].md, tbl[i].hold, tbl[i].e_pass, tbl[i].e_cnt, tbl[i].e_addr, $sformatf("tbl%0d", i));
      end

      // reset while DONE with a non-zero error count
      rst = 1'b1;
      @(negedge clk);
      for (int g = 0; g < 2; g++) begin
         check($sformatf("rst_done_ports_l%0d", g + 1), port_vec(g), 64'd0);
         check($sformatf("rst_done_result_l%0d", g + 1), res_vec(g), 64'd0);
      end
      @(negedge clk);
      rst = 1'b0;

      // reset at op 40 of a March C- run aborts without done
      f_en  = 1'b0;
      start = 1'b1;
      mode  = 2'd1;
      @(negedge clk);
      start = 1'b0;
      repeat (40) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      for (int g = 0; g < 2; g++) begin
         check($sformatf("rst_run_ports_l%0d", g + 1), port_vec(g), 64'd0);
         check($sformatf("rst_run_result_l%0d", g + 1), res_vec(g), 64'd0);
      end
      rst = 1'b0;
      seen_done = 1'b0;
      repeat (200) begin
         @(negedge clk);
         if (done[0] || done[1] || busy[0] || busy[1]) seen_done = 1'b1;
      end
      check("rst_run_no_done", 64'(seen_done), 64'd0);
      build_model(1, n_mis, first_a);
      do_run(1, 1'b0, 1'b1, 0, 0, "after_rst");

      // randomized patterns and faults against the model
      for (int r = 0; r < 8; r++) begin
         md     = int'($urandom_range(0, 3));
         f_en   = 1'($urandom_range(0, 1));
         f_addr = 4'($urandom_range(0, DEPTH - 1));
         f_bit  = int'($urandom_range(0, 7));
         f_val  = 1'($urandom_range(0, 1));
         build_model(md, n_mis, first_a);
         do_run(md, 1'($urandom_range(0, 1)), n_mis == 0, n_mis, first_a, $sformatf("rnd%0d", r));
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

endmodule
